// File: rtl/cu_pkg.sv
// Shared types for the multicycle control unit: FSM states, instruction classes,
// ALU operation codes and the opcode/func field encodings.
package cu_pkg;

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_t;

  typedef enum logic [3:0] {
    NOP, ADD, ADDU, SUB, AND, OR, SLL, JR, SYSCALL, ADDIU, LW, SW, BEQ, J, JAL
  } instr_class_t;

  typedef enum logic [3:0] {
    ALU_AND  = 4'h0,
    ALU_OR   = 4'h1,
    ALU_ADD  = 4'h2,
    ALU_ADDU = 4'h3,
    ALU_SUB  = 4'h6,
    ALU_SLL  = 4'h8
  } alu_op_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;

  localparam logic [5:0] FN_SYSCALL = 6'h0C;
  localparam logic [5:0] FN_ADD     = 6'h20;
  localparam logic [5:0] FN_ADDU    = 6'h21;
  localparam logic [5:0] FN_SUB     = 6'h22;
  localparam logic [5:0] FN_AND     = 6'h24;
  localparam logic [5:0] FN_OR      = 6'h25;
  localparam logic [5:0] FN_SLL     = 6'h00;
  localparam logic [5:0] FN_JR      = 6'h08;

  // Address arithmetic (LW/SW/ADDIU) and non-ALU classes default to ADD.
  function automatic alu_op_t alu_op_of(input instr_class_t c);
    case (c)
      ADDU:     return ALU_ADDU;
      SUB, BEQ: return ALU_SUB;
      AND:      return ALU_AND;
      OR:       return ALU_OR;
      SLL:      return ALU_SLL;
      default:  return ALU_ADD;
    endcase
  endfunction

  function automatic logic is_rtype_alu(input instr_class_t c);
    return c inside {ADD, ADDU, SUB, AND, OR, SLL};
  endfunction

endpackage

// File: rtl/multicycle_control_unit_if.sv
// Instruction/memory/datapath signal bundle of the multicycle control unit.
// illegal_inst exists only when ILLEGAL_TRAP_EN is defined.
interface multicycle_control_unit_if
  import cu_pkg::*;
#(
  parameter int OPCODE_W = 6,
  parameter int FUNC_W   = 6,
  parameter int CNT_W    = 32
);
  logic [OPCODE_W-1:0] opcode;
  logic [FUNC_W-1:0]   func;
  logic                alu_zero;
  logic                mem_ready;
  logic                mem_req;
  logic                mem_write;
  logic                ir_write;
  logic                pc_write;
  logic                alu_src;
  logic                reg_dest;
  logic                link;
  logic                mem_or_reg;
  logic                branch;
  logic                jump;
  logic                jump_register;
  logic                reg_write_enable;
  logic                does_shift_amount_need;
  alu_op_t             alu_operation;
  logic                halted;
  logic                mem_fault;
  logic [CNT_W-1:0]    retired;
`ifdef ILLEGAL_TRAP_EN
  logic                illegal_inst;
`endif

  modport master (
    input  opcode, func, alu_zero, mem_ready,
    output mem_req, mem_write, ir_write, pc_write, alu_src, reg_dest, link,
           mem_or_reg, branch, jump, jump_register, reg_write_enable,
           does_shift_amount_need, alu_operation, halted, mem_fault, retired
`ifdef ILLEGAL_TRAP_EN
    , output illegal_inst
`endif
  );

  modport slave (
    output opcode, func, alu_zero, mem_ready,
    input  mem_req, mem_write, ir_write, pc_write, alu_src, reg_dest, link,
           mem_or_reg, branch, jump, jump_register, reg_write_enable,
           does_shift_amount_need, alu_operation, halted, mem_fault, retired
`ifdef ILLEGAL_TRAP_EN
    , input illegal_inst
`endif
  );
endinterface

// File: rtl/cu_instr_decoder.sv
// Combinational opcode/func classifier; flags encodings outside the supported set.
module cu_instr_decoder
  import cu_pkg::*;
#(
  parameter int OPCODE_W = 6,
  parameter int FUNC_W   = 6
) (
  input  logic [OPCODE_W-1:0] opcode,
  input  logic [FUNC_W-1:0]   func,
  output instr_class_t        instr_class,
  output alu_op_t             alu_op,
  output logic                illegal
);

  always_comb begin
    instr_class = NOP;
    illegal     = 1'b0;
    if (opcode == OPCODE_W'(OP_RTYPE)) begin
      case (func)
        FUNC_W'(FN_ADD):     instr_class = ADD;
        FUNC_W'(FN_ADDU):    instr_class = ADDU;
        FUNC_W'(FN_SUB):     instr_class = SUB;
        FUNC_W'(FN_AND):     instr_class = AND;
        FUNC_W'(FN_OR):      instr_class = OR;
        FUNC_W'(FN_SLL):     instr_class = SLL;
        FUNC_W'(FN_JR):      instr_class = JR;
        FUNC_W'(FN_SYSCALL): instr_class = SYSCALL;
        default:             illegal     = 1'b1;
      endcase
    end else if (opcode == OPCODE_W'(OP_ADDIU)) instr_class = ADDIU;
    else if (opcode == OPCODE_W'(OP_LW))        instr_class = LW;
    else if (opcode == OPCODE_W'(OP_SW))        instr_class = SW;
    else if (opcode == OPCODE_W'(OP_BEQ))       instr_class = BEQ;
    else if (opcode == OPCODE_W'(OP_J))         instr_class = J;
    else if (opcode == OPCODE_W'(OP_JAL))       instr_class = JAL;
    else                                        illegal     = 1'b1;
    alu_op = alu_op_of(instr_class);
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle MIPS control FSM with memory handshake, wait timeout and retired counter.
// Build option ILLEGAL_TRAP_EN: unknown instructions halt and set illegal_inst.
//
// state    | meaning
// S_FETCH  | instruction read outstanding, mem_req high
// S_DECODE | classify IR, latch class; J/JAL complete here
// S_EXEC   | ALU step; BEQ/JR complete here
// S_MEM    | data read/write outstanding, mem_req high
// S_WB     | register file write-back
// S_HALT   | SYSCALL, memory timeout or trapped instruction; left only by reset
module multicycle_control_unit
  import cu_pkg::*;
#(
  parameter int OPCODE_W    = 6,
  parameter int FUNC_W      = 6,
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 32
) (
  input logic                       clk,
  input logic                       reset,
  multicycle_control_unit_if.master bus
);

  localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;

  state_t           state;
  instr_class_t     class_q;
  alu_op_t          alu_op_q;
  instr_class_t     dec_class;
  alu_op_t          dec_alu_op;
  logic             dec_illegal;
  instr_class_t     cur_class;
  logic [WAIT_W-1:0] wait_cnt;
  logic [CNT_W-1:0] retired_q;
  logic             halted_q;
  logic             fault_q;
  logic             fetch_done;
  logic             timeout_hit;
`ifdef ILLEGAL_TRAP_EN
  logic             illegal_q;
`endif

  logic mem_req_c, mem_write_c, ir_write_c, pc_write_c, alu_src_c, reg_dest_c;
  logic link_c, mem_or_reg_c, branch_c, jump_c, jump_register_c, rwe_c, shamt_c;

  cu_instr_decoder #(.OPCODE_W(OPCODE_W), .FUNC_W(FUNC_W)) u_dec (
    .opcode      (bus.opcode),
    .func        (bus.func),
    .instr_class (dec_class),
    .alu_op      (dec_alu_op),
    .illegal     (dec_illegal)
  );

  assign timeout_hit = (MEM_TIMEOUT != 0) && (wait_cnt == WAIT_W'(MEM_TIMEOUT - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_FETCH;
      class_q    <= NOP;
      alu_op_q   <= ALU_ADD;
      wait_cnt   <= '0;
      retired_q  <= '0;
      halted_q   <= 1'b0;
      fault_q    <= 1'b0;
      fetch_done <= 1'b0;
`ifdef ILLEGAL_TRAP_EN
      illegal_q  <= 1'b0;
`endif
    end else begin
      fetch_done <= 1'b0;
      case (state)
        S_FETCH, S_MEM: begin
          // A completing mem_ready wins over a timeout reached in the same cycle.
          if (bus.mem_ready) begin
            wait_cnt <= '0;
            if (state == S_FETCH) begin
              state      <= S_DECODE;
              fetch_done <= 1'b1;
            end else if (class_q == LW) begin
              state <= S_WB;
            end else begin
              state     <= S_FETCH;
              retired_q <= retired_q + 1'b1;
            end
          end else if (timeout_hit) begin
            wait_cnt <= '0;
            state    <= S_HALT;
            halted_q <= 1'b1;
            fault_q  <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        S_DECODE: begin
          class_q  <= dec_class;
          alu_op_q <= dec_alu_op;
          if (dec_class == SYSCALL) begin
            state    <= S_HALT;
            halted_q <= 1'b1;
          end
`ifdef ILLEGAL_TRAP_EN
          else if (dec_illegal) begin
            state     <= S_HALT;
            halted_q  <= 1'b1;
            illegal_q <= 1'b1;
          end
`endif
          else if (dec_illegal || dec_class inside {NOP, J, JAL}) begin
            state     <= S_FETCH;
            retired_q <= retired_q + 1'b1;
          end else begin
            state <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (class_q inside {BEQ, JR}) begin
            state     <= S_FETCH;
            retired_q <= retired_q + 1'b1;
          end else if (class_q inside {LW, SW}) begin
            state <= S_MEM;
          end else begin
            state <= S_WB;
          end
        end
        S_WB: begin
          state     <= S_FETCH;
          retired_q <= retired_q + 1'b1;
        end
        default: state <= S_HALT;
      endcase
    end
  end

  // In DECODE the class register is not loaded yet, so J/JAL use the live decode.
  assign cur_class = (state == S_DECODE) ? dec_class : class_q;

  always_comb begin
    mem_req_c       = 1'b0;
    mem_write_c     = 1'b0;
    ir_write_c      = 1'b0;
    pc_write_c      = 1'b0;
    alu_src_c       = 1'b0;
    reg_dest_c      = 1'b0;
    link_c          = 1'b0;
    mem_or_reg_c    = 1'b0;
    branch_c        = 1'b0;
    jump_c          = 1'b0;
    jump_register_c = 1'b0;
    rwe_c           = 1'b0;
    shamt_c         = 1'b0;
    case (state)
      S_FETCH: mem_req_c = 1'b1;
      S_DECODE: begin
        if (cur_class inside {J, JAL}) begin
          jump_c     = 1'b1;
          pc_write_c = 1'b1;
        end
        if (cur_class == JAL) begin
          link_c = 1'b1;
          rwe_c  = 1'b1;
        end
      end
      S_EXEC: begin
        if (cur_class == BEQ) begin
          branch_c   = 1'b1;
          pc_write_c = bus.alu_zero;
        end
        if (cur_class == JR) begin
          jump_register_c = 1'b1;
          pc_write_c      = 1'b1;
        end
      end
      S_MEM: begin
        mem_req_c   = 1'b1;
        mem_write_c = (cur_class == SW);
      end
      S_WB: begin
        rwe_c        = 1'b1;
        mem_or_reg_c = (cur_class == LW);
      end
      default: ;
    endcase
    if (state inside {S_EXEC, S_MEM, S_WB}) begin
      alu_src_c  = cur_class inside {ADDIU, LW, SW};
      reg_dest_c = is_rtype_alu(cur_class);
      shamt_c    = (cur_class == SLL);
    end
    // IR/PC+4 load is a registered pulse one cycle after the fetch completes.
    if (fetch_done) begin
      ir_write_c = 1'b1;
      pc_write_c = 1'b1;
    end
    if (reset) mem_req_c = 1'b0;
  end

  assign bus.mem_req                = mem_req_c;
  assign bus.mem_write              = mem_write_c;
  assign bus.ir_write               = ir_write_c;
  assign bus.pc_write               = pc_write_c;
  assign bus.alu_src                = alu_src_c;
  assign bus.reg_dest               = reg_dest_c;
  assign bus.link                   = link_c;
  assign bus.mem_or_reg             = mem_or_reg_c;
  assign bus.branch                 = branch_c;
  assign bus.jump                   = jump_c;
  assign bus.jump_register          = jump_register_c;
  assign bus.reg_write_enable       = rwe_c;
  assign bus.does_shift_amount_need = shamt_c;
  assign bus.alu_operation          = alu_op_q;
  assign bus.halted                 = halted_q;
  assign bus.mem_fault              = fault_q;
  assign bus.retired                = retired_q;
`ifdef ILLEGAL_TRAP_EN
  assign bus.illegal_inst           = illegal_q;
`endif

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed-vector bench for multicycle_control_unit; expectations are hand-derived.
// Covers both ILLEGAL_TRAP_EN builds.
module tb_multicycle_control_unit;
  import cu_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  int   exp_ret = 0;

  multicycle_control_unit_if #(.OPCODE_W(6), .FUNC_W(6), .CNT_W(32)) bus ();

  multicycle_control_unit #(
    .OPCODE_W(6), .FUNC_W(6), .MEM_TIMEOUT(15), .CNT_W(32)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [14:0] strobes();
    return {bus.mem_req, bus.mem_write, bus.ir_write, bus.pc_write, bus.alu_src,
            bus.reg_dest, bus.link, bus.mem_or_reg, bus.branch, bus.jump,
            bus.jump_register, bus.reg_write_enable, bus.does_shift_amount_need,
            bus.halted, bus.mem_fault};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch_ok(input logic [5:0] op, input logic [5:0] fn);
    bus.mem_ready = 1'b1;
    bus.opcode    = op;
    bus.func      = fn;
    tick();
    bus.mem_ready = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.mem_ready = 1'b0;
    @(posedge clk);
    #1;
    reset   = 1'b0;
    exp_ret = 0;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.mem_ready = 1'b0; bus.opcode = '0; bus.func = '0; bus.alu_zero = 1'b0;
    #3;
    checks++;
    if (strobes() !== 15'd0) begin errors++; $display("FAIL reset_strobes got %b exp 0", strobes()); end
    checks++;
    if (bus.retired !== 32'd0 || bus.alu_operation !== ALU_ADD) begin
      errors++; $display("FAIL reset_regs got ret=%0d alu=%0h exp ret=0 alu=2", bus.retired, bus.alu_operation);
    end
`ifdef ILLEGAL_TRAP_EN
    checks++;
    if (bus.illegal_inst !== 1'b0) begin errors++; $display("FAIL reset_illegal got %b exp 0", bus.illegal_inst); end
`endif
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    checks++;
    if (bus.mem_req !== 1'b1) begin errors++; $display("FAIL reset_release_req got %b exp 1", bus.mem_req); end
  endtask

  task automatic test_add();
    bus.opcode = 6'h00; bus.func = 6'h20; bus.mem_ready = 1'b1;
    #1;
    checks++;
    if ({bus.mem_req, bus.reg_write_enable, bus.ir_write} !== 3'b100) begin
      errors++; $display("FAIL add_fetch got %b exp 100", {bus.mem_req, bus.reg_write_enable, bus.ir_write});
    end
    tick(); bus.mem_ready = 1'b0; #1;
    checks++;
    if ({bus.ir_write, bus.pc_write, bus.mem_req, bus.reg_write_enable} !== 4'b1100) begin
      errors++; $display("FAIL add_decode got %b exp 1100", {bus.ir_write, bus.pc_write, bus.mem_req, bus.reg_write_enable});
    end
    tick();
    checks++;
    if ({bus.reg_dest, bus.reg_write_enable, bus.alu_src} !== 3'b100 || bus.alu_operation !== ALU_ADD) begin
      errors++; $display("FAIL add_exec got %b alu=%0h exp 100 alu=2", {bus.reg_dest, bus.reg_write_enable, bus.alu_src}, bus.alu_operation);
    end
    tick();
    checks++;
    if ({bus.reg_write_enable, bus.reg_dest, bus.mem_or_reg} !== 3'b110 || bus.retired !== 32'd0) begin
      errors++; $display("FAIL add_wb got %b ret=%0d exp 110 ret=0", {bus.reg_write_enable, bus.reg_dest, bus.mem_or_reg}, bus.retired);
    end
    tick();
    exp_ret = 1;
    checks++;
    if (bus.retired !== 32'd1 || bus.mem_req !== 1'b1 || bus.reg_write_enable !== 1'b0) begin
      errors++; $display("FAIL add_retire got ret=%0d req=%b exp ret=1 req=1", bus.retired, bus.mem_req);
    end
  endtask

  // LW: minimum 5 cycles plus three wait cycles in each memory phase = 11.
  task automatic test_lw();
    logic held = 1'b1;
    logic saw_mw = 1'b0;
    bus.opcode = 6'h23; bus.func = 6'h00;
    for (int i = 0; i < 3; i++) begin
      bus.mem_ready = 1'b0;
      if (bus.mem_req !== 1'b1) held = 1'b0;
      if (bus.mem_write) saw_mw = 1'b1;
      tick();
    end
    fetch_ok(6'h23, 6'h00);
    tick();
    checks++;
    if (bus.alu_src !== 1'b1 || bus.alu_operation !== ALU_ADD) begin
      errors++; $display("FAIL lw_exec got src=%b alu=%0h exp src=1 alu=2", bus.alu_src, bus.alu_operation);
    end
    tick();
    for (int i = 0; i < 3; i++) begin
      if (bus.mem_req !== 1'b1) held = 1'b0;
      if (bus.mem_write) saw_mw = 1'b1;
      tick();
    end
    bus.mem_ready = 1'b1;
    if (bus.mem_req !== 1'b1) held = 1'b0;
    if (bus.mem_write) saw_mw = 1'b1;
    tick();
    bus.mem_ready = 1'b0;
    checks++;
    if ({bus.reg_write_enable, bus.mem_or_reg} !== 2'b11 || bus.retired !== 32'(exp_ret)) begin
      errors++; $display("FAIL lw_wb got %b ret=%0d exp 11 ret=%0d", {bus.reg_write_enable, bus.mem_or_reg}, bus.retired, exp_ret);
    end
    tick();
    exp_ret++;
    checks++;
    if (bus.retired !== 32'(exp_ret) || bus.mem_req !== 1'b1) begin
      errors++; $display("FAIL lw_retire got ret=%0d req=%b exp ret=%0d req=1", bus.retired, bus.mem_req, exp_ret);
    end
    checks++;
    if (held !== 1'b1 || saw_mw !== 1'b0) begin
      errors++; $display("FAIL lw_handshake got held=%b mw=%b exp held=1 mw=0", held, saw_mw);
    end
  endtask

  task automatic test_beq();
    for (int z = 0; z < 2; z++) begin
      fetch_ok(6'h04, 6'h00);
      tick();
      bus.alu_zero = z[0];
      #1;
      checks++;
      if ({bus.branch, bus.pc_write} !== {1'b1, z[0]}) begin
        errors++; $display("FAIL beq_exec_z%0d got %b exp %b", z, {bus.branch, bus.pc_write}, {1'b1, z[0]});
      end
      tick();
      bus.alu_zero = 1'b0;
      exp_ret++;
      checks++;
      if (bus.retired !== 32'(exp_ret) || bus.mem_req !== 1'b1) begin
        errors++; $display("FAIL beq_retire_z%0d got ret=%0d exp %0d", z, bus.retired, exp_ret);
      end
    end
  endtask

  task automatic test_jal();
    fetch_ok(6'h03, 6'h00);
    checks++;
    if ({bus.link, bus.reg_write_enable, bus.jump, bus.pc_write, bus.jump_register} !== 5'b11110) begin
      errors++; $display("FAIL jal_decode got %b exp 11110", {bus.link, bus.reg_write_enable, bus.jump, bus.pc_write, bus.jump_register});
    end
    tick();
    exp_ret++;
    checks++;
    if (bus.retired !== 32'(exp_ret) || bus.mem_req !== 1'b1 || bus.jump !== 1'b0) begin
      errors++; $display("FAIL jal_retire got ret=%0d req=%b exp ret=%0d req=1", bus.retired, bus.mem_req, exp_ret);
    end
  endtask

  task automatic test_sw_jr_sll();
    fetch_ok(6'h2B, 6'h00);
    tick();
    bus.mem_ready = 1'b1;
    #1;
    checks++;
    if ({bus.alu_src, bus.mem_req} !== 2'b10) begin
      errors++; $display("FAIL sw_exec got %b exp 10", {bus.alu_src, bus.mem_req});
    end
    tick();
    checks++;
    if ({bus.mem_req, bus.mem_write} !== 2'b11) begin
      errors++; $display("FAIL sw_mem got %b exp 11", {bus.mem_req, bus.mem_write});
    end
    tick();
    bus.mem_ready = 1'b0;
    exp_ret++;
    checks++;
    if (bus.retired !== 32'(exp_ret) || bus.reg_write_enable !== 1'b0) begin
      errors++; $display("FAIL sw_retire got ret=%0d rwe=%b exp ret=%0d rwe=0", bus.retired, bus.reg_write_enable, exp_ret);
    end
    fetch_ok(6'h00, 6'h08);
    tick();
    checks++;
    if ({bus.jump_register, bus.pc_write, bus.reg_write_enable} !== 3'b110) begin
      errors++; $display("FAIL jr_exec got %b exp 110", {bus.jump_register, bus.pc_write, bus.reg_write_enable});
    end
    tick();
    exp_ret++;
    fetch_ok(6'h00, 6'h00);
    tick();
    checks++;
    if ({bus.does_shift_amount_need, bus.reg_dest} !== 2'b11 || bus.alu_operation !== ALU_SLL) begin
      errors++; $display("FAIL sll_exec got %b alu=%0h exp 11 alu=8", {bus.does_shift_amount_need, bus.reg_dest}, bus.alu_operation);
    end
    tick();
    tick();
    exp_ret++;
    checks++;
    if (bus.retired !== 32'(exp_ret)) begin
      errors++; $display("FAIL jr_sll_retire got %0d exp %0d", bus.retired, exp_ret);
    end
  endtask

  task automatic test_illegal();
    fetch_ok(6'h3F, 6'h00);
    tick();
`ifdef ILLEGAL_TRAP_EN
    checks++;
    if ({bus.halted, bus.illegal_inst, bus.mem_req} !== 3'b110 || bus.retired !== 32'(exp_ret)) begin
      errors++; $display("FAIL illegal_trap got %b ret=%0d exp 110 ret=%0d", {bus.halted, bus.illegal_inst, bus.mem_req}, bus.retired, exp_ret);
    end
    do_reset();
`else
    exp_ret++;
    checks++;
    if ({bus.halted, bus.mem_req} !== 2'b01 || bus.retired !== 32'(exp_ret)) begin
      errors++; $display("FAIL illegal_nop got %b ret=%0d exp 01 ret=%0d", {bus.halted, bus.mem_req}, bus.retired, exp_ret);
    end
`endif
  endtask

  task automatic test_syscall();
    fetch_ok(6'h00, 6'h0C);
    tick();
    checks++;
    if ({bus.halted, bus.mem_fault, bus.mem_req} !== 3'b100 || bus.retired !== 32'(exp_ret)) begin
      errors++; $display("FAIL syscall_halt got %b ret=%0d exp 100 ret=%0d", {bus.halted, bus.mem_fault, bus.mem_req}, bus.retired, exp_ret);
    end
    bus.mem_ready = 1'b1;
    repeat (3) tick();
    checks++;
    if ({bus.halted, bus.mem_req, bus.ir_write} !== 3'b100) begin
      errors++; $display("FAIL syscall_sticky got %b exp 100", {bus.halted, bus.mem_req, bus.ir_write});
    end
    do_reset();
    checks++;
    if (strobes() !== 15'b100000000000000 || bus.retired !== 32'd0) begin
      errors++; $display("FAIL syscall_reset got %b ret=%0d exp 100000000000000 ret=0", strobes(), bus.retired);
    end
  endtask

  task automatic test_timeout();
    bus.mem_ready = 1'b0;
    repeat (14) tick();
    checks++;
    if ({bus.halted, bus.mem_fault, bus.mem_req} !== 3'b001) begin
      errors++; $display("FAIL timeout_early got %b exp 001", {bus.halted, bus.mem_fault, bus.mem_req});
    end
    tick();
    checks++;
    if ({bus.halted, bus.mem_fault, bus.mem_req} !== 3'b110) begin
      errors++; $display("FAIL timeout_hit got %b exp 110", {bus.halted, bus.mem_fault, bus.mem_req});
    end
    bus.mem_ready = 1'b1;
    repeat (3) tick();
    checks++;
    if ({bus.halted, bus.mem_fault, bus.mem_req} !== 3'b110) begin
      errors++; $display("FAIL timeout_sticky got %b exp 110", {bus.halted, bus.mem_fault, bus.mem_req});
    end
    reset = 1'b1;
    #1;
    checks++;
    if (strobes() !== 15'd0 || bus.retired !== 32'd0) begin
      errors++; $display("FAIL timeout_reset got %b exp 0", strobes());
    end
    do_reset();
  endtask

  task automatic test_timeout_priority();
    bus.mem_ready = 1'b0;
    repeat (14) tick();
    bus.mem_ready = 1'b1; bus.opcode = 6'h02; bus.func = 6'h00;
    tick();
    bus.mem_ready = 1'b0;
    checks++;
    if ({bus.halted, bus.mem_fault, bus.ir_write, bus.jump} !== 4'b0011) begin
      errors++; $display("FAIL timeout_priority got %b exp 0011", {bus.halted, bus.mem_fault, bus.ir_write, bus.jump});
    end
    tick();
    checks++;
    if (bus.retired !== 32'd1 || bus.mem_req !== 1'b1) begin
      errors++; $display("FAIL j_retire got ret=%0d req=%b exp ret=1 req=1", bus.retired, bus.mem_req);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_lw();
    test_beq();
    test_jal();
    test_sw_jr_sll();
    test_illegal();
    test_syscall();
    test_timeout();
    test_timeout_priority();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1);
  end

endmodule
